// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair: one bit per cycle, signs applied in a final FIX cycle.
// Optional MTHI/MTLO writes are compiled in when MDU_MTHILO_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] crs,
    input  logic [WIDTH-1:0] crt,
    input  logic             mf_rd,
    input  logic             mf_sel,
    input  logic             mt_wr,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] upper_reg, upper_next;   // product high half / partial remainder
    logic [WIDTH-1:0] lower_reg, lower_next;   // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] opnd_reg, opnd_next;     // multiplicand or divisor magnitude
    logic             div_reg, div_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic             dz_reg, dz_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             done_reg, done_next;

    // Operand magnitudes and signs, only meaningful in the launch cycle
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & crs[WIDTH-1];
        b_neg     = is_signed & crt[WIDTH-1];
        a_mag     = a_neg ? -crs : crs;
        b_mag     = b_neg ? -crt : crt;
    end

    // Shift-add step: add the multiplicand when the current multiplier bit is set
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = opnd_reg[gi] & lower_reg[0];
        end
    endgenerate

    assign mul_sum = {1'b0, upper_reg} + {1'b0, addend};

    // Restoring step: remainder stays below the divisor, so WIDTH+1 bits hold the trial difference
    logic [WIDTH:0] div_diff;
    assign div_diff = {upper_reg, lower_reg[WIDTH-1]} - {1'b0, opnd_reg};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_q_reg ? -{upper_reg, lower_reg} : {upper_reg, lower_reg};
    assign quot_fix = neg_q_reg ? -lower_reg : lower_reg;
    assign rem_fix  = neg_r_reg ? -upper_reg : upper_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            upper_reg <= '0;
            lower_reg <= '0;
            opnd_reg  <= '0;
            div_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            dz_reg    <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            upper_reg <= upper_next;
            lower_reg <= lower_next;
            opnd_reg  <= opnd_next;
            div_reg   <= div_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            dz_reg    <= dz_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        upper_next = upper_reg;
        lower_next = lower_reg;
        opnd_next  = opnd_reg;
        div_next   = div_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        dz_next    = dz_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    count_next = '0;
                    upper_next = '0;
                    div_next   = op[1];
                    neg_q_next = a_neg ^ b_neg;
                    neg_r_next = a_neg;
                    dz_next    = (crt == '0);
                    lower_next = op[1] ? a_mag : b_mag;
                    opnd_next  = op[1] ? b_mag : a_mag;
                end
`ifdef MDU_MTHILO_EN
                else if (mt_wr) begin
                    if (mt_sel) begin
                        hi_next = mt_data;
                    end else begin
                        lo_next = mt_data;
                    end
                end
`endif
            end

            S_RUN: begin
                if (count_reg == LAST_ITER) begin
                    state_next = S_FIX;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CW'(1);
                end

                if (div_reg) begin
                    if (!div_diff[WIDTH]) begin
                        upper_next = div_diff[WIDTH-1:0];
                        lower_next = {lower_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        upper_next = {upper_reg[WIDTH-2:0], lower_reg[WIDTH-1]};
                        lower_next = {lower_reg[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    upper_next = mul_sum[WIDTH:1];
                    lower_next = {mul_sum[0], lower_reg[WIDTH-1:1]};
                end
            end

            S_FIX: begin
                state_next = S_IDLE;
                done_next  = 1'b1;
                if (div_reg) begin
                    // Divide by zero yields an all-ones quotient; the remainder is already the dividend
                    lo_next = dz_reg ? '1 : quot_fix;
                    hi_next = rem_fix;
                end else begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifndef MDU_MTHILO_EN
    logic unused_mt;
    assign unused_mt = ^{mt_wr, mt_sel, mt_data};
`endif

    assign busy    = (state_reg != S_IDLE);
    assign done    = done_reg;
    assign stall   = mf_rd & busy;
    assign mf_data = mf_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI:LO pushed at launch, popped and compared when done pulses.
`timescale 1ns/1ps
module tb_mult_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 2;   // negedges from the one after the start edge up to the done cycle

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   crs = '0;
    logic [W-1:0]   crt = '0;
    logic           mf_rd = 1'b0;
    logic           mf_sel = 1'b0;
    logic           mt_wr = 1'b0;
    logic           mt_sel = 1'b0;
    logic [W-1:0]   mt_data = '0;
    logic           busy;
    logic           done;
    logic           stall;
    logic [W-1:0]   mf_data;

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] hilo_model = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .crs     (crs),
        .crt     (crt),
        .mf_rd   (mf_rd),
        .mf_sel  (mf_sel),
        .mt_wr   (mt_wr),
        .mt_sel  (mt_sel),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .mf_data (mf_data)
    );

    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        logic [2*W-1:0]  res;
        res = '0;
        case (o)
            2'b00: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                res = sp;
            end
            2'b01: begin
                up  = {32'b0, a} * {32'b0, b};
                res = up;
            end
            2'b10: begin
                if (b == '0) begin
                    res = {a, {W{1'b1}}};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    q   = $signed(a) / $signed(b);
                    r   = $signed(a) % $signed(b);
                    res = {r, q};
                end
            end
            default: begin
                if (b == '0) res = {a, {W{1'b1}}};
                else         res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] e);
        op    = o;
        crs   = a;
        crt   = b;
        start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        crs   = $urandom;
        crt   = $urandom;
        op    = 2'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        mf_rd  = 1'b1;
        mf_sel = 1'b0;
        #1 lo  = mf_data;
        mf_sel = 1'b1;
        #1 hi  = mf_data;
        mf_rd  = 1'b0;
        mf_sel = 1'b0;
    endtask

    task automatic run_one(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] e, output logic [W-1:0] hi, output logic [W-1:0] lo,
                           output int lat);
        @(negedge clk);
        drive_start(o, a, b, e);
        wait_done(lat);
        read_hilo(hi, lo);
        $display("op=%0d crs=%h crt=%h -> hi=%h lo=%h latency=%0d", o, a, b, hi, lo, lat);
    endtask

    task automatic test_reset();
        logic [W-1:0] hi, lo;
        rst_n = 1'b0;
        start = 1'b1;
        op    = 2'b01;
        crs   = 32'd5;
        crt   = 32'd5;
        mf_rd = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", stall); end
        start = 1'b0;
        read_hilo(hi, lo);
        checks++;
        if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h expected 0", {hi, lo}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b expected 0", busy); end
        $display("reset released hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mult();
        logic [W-1:0]   hi, lo, a, b;
        logic [1:0]     o;
        logic [2*W-1:0] e, exp_v;
        int             lat;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin o = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; e = {32'hFFFF_FFFE, 32'h0000_0001}; end
                1: begin o = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7;         e = {32'hFFFF_FFFF, 32'hFFFF_FFEB}; end
                2: begin o = 2'b00; a = 32'h8000_0000; b = 32'h8000_0000; e = {32'h4000_0000, 32'h0000_0000}; end
                3: begin o = 2'b00; a = 32'h8000_0000; b = 32'd1;         e = {32'hFFFF_FFFF, 32'h8000_0000}; end
                default: begin
                    o = 2'($urandom_range(0, 1));
                    a = $urandom;
                    b = $urandom;
                    e = model(o, a, b);
                end
            endcase
            run_one(o, a, b, e, hi, lo, lat);
            exp_v      = sb_q.pop_front();
            hilo_model = exp_v;
            checks++;
            if ({hi, lo} !== exp_v) begin errors++; $display("FAIL mult_result got %h expected %h", {hi, lo}, exp_v); end
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL mult_latency got %0d expected %0d", lat, LAT); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b expected 0", done); end
        end
    endtask

    task automatic test_div();
        logic [W-1:0]   hi, lo, a, b;
        logic [1:0]     o;
        logic [2*W-1:0] e, exp_v;
        int             lat;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin o = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;         e = {32'hFFFF_FFFF, 32'hFFFF_FFFD}; end
                1: begin o = 2'b11; a = 32'd100;       b = 32'd0;         e = {32'd100,       32'hFFFF_FFFF}; end
                2: begin o = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF; e = {32'h0,         32'h8000_0000}; end
                3: begin o = 2'b10; a = 32'd7;         b = 32'hFFFF_FFFE; e = {32'h1,         32'hFFFF_FFFD}; end
                4: begin o = 2'b10; a = 32'hFFFF_FFF8; b = 32'd0;         e = {32'hFFFF_FFF8, 32'hFFFF_FFFF}; end
                5: begin o = 2'b11; a = 32'hFFFF_FFFF; b = 32'd3;         e = {32'h0,         32'h5555_5555}; end
                default: begin
                    o = 2'($urandom_range(2, 3));
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 28);
                    e = model(o, a, b);
                end
            endcase
            run_one(o, a, b, e, hi, lo, lat);
            exp_v      = sb_q.pop_front();
            hilo_model = exp_v;
            checks++;
            if ({hi, lo} !== exp_v) begin errors++; $display("FAIL div_result got %h expected %h", {hi, lo}, exp_v); end
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL div_latency got %0d expected %0d", lat, LAT); end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0]   old_lo, hi;
        logic [2*W-1:0] exp_v;
        int             lat;
        old_lo = hilo_model[W-1:0];
        @(negedge clk);
        mf_rd  = 1'b1;
        mf_sel = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mf_data !== old_lo) begin
            errors++;
            $display("FAIL idle_read stall=%b mf_data=%h expected stall=0 mf_data=%h", stall, mf_data, old_lo);
        end
        @(negedge clk);
        drive_start(2'b01, 32'd6, 32'd7, {32'd0, 32'd42});
        mf_rd  = 1'b1;
        mf_sel = 1'b0;
        lat    = 1;
        while (done !== 1'b1 && lat < 200) begin
            checks++;
            if (stall !== 1'b1 || mf_data !== old_lo) begin
                errors++;
                $display("FAIL stall_hold stall=%b mf_data=%h expected stall=1 mf_data=%h", stall, mf_data, old_lo);
            end
            if (lat == 5) begin
                start = 1'b1;
                op    = 2'b10;
                crs   = 32'd1000;
                crt   = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (stall !== 1'b0 || mf_data !== 32'd42) begin
            errors++;
            $display("FAIL stall_release stall=%b mf_data=%h expected stall=0 mf_data=0000002a", stall, mf_data);
        end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL stall_latency got %0d expected %0d", lat, LAT); end
        mf_sel = 1'b1;
        #1 hi  = mf_data;
        mf_rd  = 1'b0;
        mf_sel = 1'b0;
        exp_v      = sb_q.pop_front();
        hilo_model = exp_v;
        checks++;
        if (hi !== exp_v[2*W-1:W]) begin errors++; $display("FAIL stall_hi got %h expected %h", hi, exp_v[2*W-1:W]); end
        $display("op=1 crs=00000006 crt=00000007 with mf_rd stall -> lo=0000002a hi=%h latency=%0d", hi, lat);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start busy got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   hi, lo, a1, b1, a2, b2;
        logic [2*W-1:0] exp_v;
        int             lat;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom_range(1, 1000);
        @(negedge clk);
        drive_start(2'b01, a1, b1, model(2'b01, a1, b1));
        wait_done(lat);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done got %b expected 0", busy); end
        read_hilo(hi, lo);
        exp_v = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_first got %h expected %h", {hi, lo}, exp_v); end
        $display("op=1 crs=%h crt=%h -> hi=%h lo=%h latency=%0d", a1, b1, hi, lo, lat);
        drive_start(2'b11, a2, b2, model(2'b11, a2, b2));
        wait_done(lat);
        read_hilo(hi, lo);
        exp_v      = sb_q.pop_front();
        hilo_model = exp_v;
        checks++;
        if ({hi, lo} !== exp_v) begin errors++; $display("FAIL b2b_second got %h expected %h", {hi, lo}, exp_v); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL b2b_latency got %0d expected %0d", lat, LAT); end
        $display("op=3 crs=%h crt=%h -> hi=%h lo=%h latency=%0d", a2, b2, hi, lo, lat);
    endtask

    task automatic test_mthilo();
        logic [W-1:0]   hi, lo;
        logic [2*W-1:0] exp_v;
        int             lat;
`ifdef MDU_MTHILO_EN
        @(negedge clk);
        mt_wr   = 1'b1;
        mt_sel  = 1'b1;
        mt_data = 32'h1234_5678;
        @(negedge clk);
        mt_wr   = 1'b0;
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== hilo_model[W-1:0]) begin
            errors++;
            $display("FAIL mthi got hi=%h lo=%h expected hi=12345678 lo=%h", hi, lo, hilo_model[W-1:0]);
        end
        mt_wr   = 1'b1;
        mt_sel  = 1'b0;
        mt_data = 32'hCAFE_F00D;
        @(negedge clk);
        mt_wr   = 1'b0;
        read_hilo(hi, lo);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h expected hi=12345678 lo=cafef00d", hi, lo);
        end
        $display("mt writes -> hi=%h lo=%h", hi, lo);
        mt_wr   = 1'b1;
        mt_sel  = 1'b1;
        mt_data = 32'hDEAD_BEEF;
        drive_start(2'b01, 32'd9, 32'd9, {32'd0, 32'd81});
        mt_data = 32'hBAD0_BAD0;
        @(negedge clk);
        mt_wr   = 1'b0;
        mf_rd   = 1'b1;
        mf_sel  = 1'b1;
        #1;
        checks++;
        if (mf_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mt_while_busy got hi=%h expected 12345678", mf_data);
        end
        mf_rd  = 1'b0;
        mf_sel = 1'b0;
        wait_done(lat);
        lat = lat + 1;
`else
        @(negedge clk);
        mt_wr   = 1'b1;
        mt_sel  = 1'b1;
        mt_data = 32'h1234_5678;
        @(negedge clk);
        mt_sel  = 1'b0;
        @(negedge clk);
        mt_wr   = 1'b0;
        read_hilo(hi, lo);
        checks++;
        if ({hi, lo} !== hilo_model) begin
            errors++;
            $display("FAIL mt_ignored got %h expected %h", {hi, lo}, hilo_model);
        end
        $display("mt writes ignored -> hi=%h lo=%h", hi, lo);
        @(negedge clk);
        drive_start(2'b01, 32'd9, 32'd9, {32'd0, 32'd81});
        wait_done(lat);
        lat = lat + 1;
`endif
        read_hilo(hi, lo);
        exp_v      = sb_q.pop_front();
        hilo_model = exp_v;
        checks++;
        if ({hi, lo} !== exp_v) begin errors++; $display("FAIL mt_op_result got %h expected %h", {hi, lo}, exp_v); end
        checks++;
        if (lat != LAT + 1) begin errors++; $display("FAIL mt_op_latency got %0d expected %0d", lat - 1, LAT); end
        $display("op=1 crs=00000009 crt=00000009 -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0]   hi, lo, a, b;
        logic [2*W-1:0] exp_v, e;
        int             lat;
        bit             saw_done;
        @(negedge clk);
        drive_start(2'b01, 32'd12345, 32'd678, model(2'b01, 32'd12345, 32'd678));
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        hilo_model = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags busy=%b done=%b expected busy=0 done=0", busy, done);
        end
        read_hilo(hi, lo);
        checks++;
        if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo got %h expected 0", {hi, lo}); end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got 1 expected 0"); end
        $display("reset mid-operation -> hi=%h lo=%h", hi, lo);
        a = $urandom;
        b = $urandom;
        e = model(2'b00, a, b);
        run_one(2'b00, a, b, e, hi, lo, lat);
        exp_v      = sb_q.pop_front();
        hilo_model = exp_v;
        checks++;
        if ({hi, lo} !== exp_v) begin errors++; $display("FAIL after_abort got %h expected %h", {hi, lo}, exp_v); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL after_abort_latency got %0d expected %0d", lat, LAT); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_back_to_back();
        test_mthilo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
